// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the seq_scan_arbiter slice.
//   ctrl_state_t : controller FSM states
//   det_state_t  : 1010 detector states (S0..S4, S4 = hit)
//   PATTERN      : serial pattern searched for, MSB first
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    RESP
  } ctrl_state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq1010_det.sv
// Overlapping Moore detector for the serial pattern PATTERN (1010).
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   clr    : synchronous clear to S0 (start of a new word)
//   bit_in : serial input bit, sampled every clock
//   hit    : high while the detector sits in S4 (one cycle after the final 0)
module seq1010_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_in,
  output logic hit
);

  det_state_t state;
  det_state_t state_nxt;

  // Next-state table; S3/S4 fall back to partial-match states so overlaps count.
  always_comb begin
    state_nxt = state;
    case (state)
      S0:      state_nxt = (bit_in == PATTERN[3]) ? S1 : S0;
      S1:      state_nxt = (bit_in == PATTERN[2]) ? S2 : S1;
      S2:      state_nxt = (bit_in == PATTERN[1]) ? S3 : S0;
      S3:      state_nxt = (bit_in == PATTERN[0]) ? S4 : S1;
      S4:      state_nxt = (bit_in == PATTERN[1]) ? S3 : S0;
      default: state_nxt = S0;
    endcase
  end

  // hit is registered alongside the state so it is a clean decode of S4.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state <= S0;
      hit   <= 1'b0;
    end else begin
      state <= state_nxt;
      hit   <= (state_nxt == S4);
    end
  end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter sharing one serial 1010 detector between N_REQ requesters.
// A granted word is shifted MSB-first through the detector; the number of
// overlapping hits is returned together with the requester id.
//   clk, reset : clock, synchronous active-high reset
//   req_valid  : per-requester word valid
//   req_data   : word i in bits [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept, combinational, only in IDLE
//   rsp_valid  : result available (held until rsp_ready)
//   rsp_ready  : result consumed
//   rsp_id     : requester whose word was scanned
//   rsp_count  : number of 1010 hits in that word (saturating)
//   busy       : high in any state except IDLE
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CNT_W-1:0]         rsp_count,
  output logic                     busy
);

  localparam int unsigned BCNT_W = $clog2(WIDTH + 1);

  ctrl_state_t       state;
  logic [WIDTH-1:0]  shift_reg;
  logic [BCNT_W-1:0] bit_cnt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [CNT_W-1:0]  cnt;

  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic              accept;
  logic [WIDTH-1:0]  sel_data;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              det_hit;

  // Circular search starting one past the last granted index.
  always_comb begin
    idx       = ptr;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Accept only in IDLE; reset dominates so no grant leaks during reset.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (!reset && (state == IDLE) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
      accept               = 1'b1;
    end
  end

  // Mux of the granted word.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Saturating hit counter; hits seen in DRAIN belong to the last shifted bit.
  always_comb begin
    cnt_nxt = cnt;
    if (det_hit && ((state == SHIFT) || (state == DRAIN)) && (cnt != '1)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  seq1010_det u_det (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .bit_in (shift_reg[WIDTH-1]),
    .hit    (det_hit)
  );

  // Controller: IDLE -> SHIFT -> DRAIN -> RESP -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= ID_W'(N_REQ - 1);
      shift_reg <= '0;
      bit_cnt   <= '0;
      gnt_id    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= sel_data;
            gnt_id    <= grant_idx;
            bit_cnt   <= BCNT_W'(WIDTH);
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt - BCNT_W'(1);
          cnt       <= cnt_nxt;
          if (bit_cnt == BCNT_W'(1)) state <= DRAIN;
        end
        DRAIN: begin
          cnt       <= cnt_nxt;
          rsp_count <= cnt_nxt;
          rsp_id    <= gnt_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= gnt_id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter: directed cases plus random words,
// checked against a sliding-window hit count and a round-robin pick model.
module tb_seq_scan_arbiter;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ID_W  = 1;
  localparam int unsigned CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [CNT_W-1:0]       rsp_count;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  int rr_last;

  always #5 clk = ~clk;

  seq_scan_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  // Overlapping 1010 occurrences in the word read MSB first, saturated.
  function automatic int ref_hits(input logic [WIDTH-1:0] w);
    int n;
    logic [WIDTH-1:0] t;
    n = 0;
    for (int i = 0; i <= int'(WIDTH) - 4; i++) begin
      t = w << i;
      if (t[WIDTH-1 -: 4] == 4'b1010) n++;
    end
    if (n > (2 ** CNT_W) - 1) n = (2 ** CNT_W) - 1;
    return n;
  endfunction

  // First valid requester after the last one served, circular.
  function automatic int ref_pick(input logic [N_REQ-1:0] v);
    int idx;
    logic [N_REQ-1:0] t;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (rr_last + k) % int'(N_REQ);
      t = v >> idx;
      if (t[0]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word from arbitration to response; called at a negedge with DUT in IDLE.
  task automatic run_word(input logic [N_REQ-1:0] v, input logic [N_REQ*WIDTH-1:0] d,
                          input bit keep, input int hold);
    int g;
    int lat;
    int exp_cnt;
    logic [WIDTH-1:0] w;
    logic [N_REQ-1:0] onehot;
    req_valid = v;
    req_data  = d;
    #1;
    g       = ref_pick(v);
    onehot  = N_REQ'(1) << g;
    w       = WIDTH'(d >> (g * int'(WIDTH)));
    exp_cnt = ref_hits(w);
    check("grant", 32'(req_ready), 32'(onehot));
    @(posedge clk);
    #1;
    if (!keep) req_valid = '0;
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || lat > 40) break;
      check("busy_scan", 32'(busy), 32'(1));
      check("ready_scan", 32'(req_ready), 32'(0));
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(WIDTH + 2));
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_count", 32'(rsp_count), 32'(exp_cnt));
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid), 32'(1));
        check("hold_id", 32'(rsp_id), 32'(g));
        check("hold_count", 32'(rsp_count), 32'(exp_cnt));
        check("hold_busy", 32'(busy), 32'(1));
        check("hold_ready", 32'(req_ready), 32'(0));
      end
      rsp_ready = 1'b1;
    end
    rr_last = g;
    @(posedge clk);
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_data  = '0;
    rr_last   = int'(N_REQ) - 1;

    // Reset dominates: no grant even with every requester valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_valid", 32'(rsp_valid), 32'(0));
    req_valid = '0;
    reset     = 1'b0;
    @(negedge clk);
    check("reset_id", 32'(rsp_id), 32'(0));
    check("reset_count", 32'(rsp_count), 32'(0));
    check("reset_busy2", 32'(busy), 32'(0));

    // Directed words.
    run_word(2'b01, {8'h00, 8'b10101010}, 1'b0, 0);
    run_word(2'b10, {8'b00001010, 8'h00}, 1'b0, 0);
    run_word(2'b10, {8'b10100000, 8'h00}, 1'b0, 0);
    run_word(2'b01, {8'h00, 8'b00000010}, 1'b0, 0);
    run_word(2'b01, {8'h00, 8'b10000000}, 1'b0, 0);

    // Both held valid: alternating grants, back-to-back at minimum spacing.
    repeat (4) run_word(2'b11, {8'h0A, 8'hAA}, 1'b1, 0);
    req_valid = '0;

    // Response back-pressure.
    run_word(2'b01, {8'h00, 8'h5A}, 1'b0, 5);

    // Reset in the middle of SHIFT drops the word and the pointer.
    req_valid = 2'b10;
    req_data  = {8'hAA, 8'h00};
    #1;
    check("mid_grant", 32'(req_ready), 32'(2'b10));
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    rr_last = int'(N_REQ) - 1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'(0));
    check("mid_valid", 32'(rsp_valid), 32'(0));
    repeat (12) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(rsp_valid), 32'(0));
    end
    run_word(2'b11, {8'hAA, 8'hAA}, 1'b0, 0);

    // Random words, masks and back-pressure.
    repeat (20) begin
      run_word(N_REQ'($urandom_range(1, 3)), (N_REQ*WIDTH)'($urandom), 1'b0,
               int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_arbiter.md
Name: seq_scan_arbiter

Overview:
- Shares one serial "1010" Moore pattern detector between N_REQ requesters.
- Each requester submits a WIDTH-bit word over a valid/ready handshake.
- The block arbitrates round-robin, shifts the granted word MSB-first into the detector at one bit per clock, counts overlapping hits and returns the count with the requester id.
- Sits between the per-channel capture logic and the result/status collector.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- WIDTH, 8, word length in bits (≥4).
- ID_W, 1, requester id width = clog2(N_REQ), min 1.
- CNT_W, 4, hit counter width; must hold (WIDTH-2)/2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  N_REQ*WIDTH  word i in bits [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-hot grant/accept, combinational
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  ID_W  index of requester whose word was scanned
- rsp_count  out  CNT_W  number of 1010 hits in that word
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, dominates all other inputs): FSM to IDLE; detector to S0; rsp_valid=0; rsp_id=0; rsp_count=0; busy=0; req_ready=0; round-robin pointer = N_REQ-1, so req 0 has top priority first.
- Controller FSM: IDLE → SHIFT → DRAIN → RESP → IDLE.
- IDLE, cycle T0, with any req_valid set:
  - Grant the first valid index after the last granted index, circular.
  - req_ready[g]=1 in that cycle only; all other req_ready bits are 0.
  - Capture req_data[g] into the shift register; latch g.
  - Clear the detector to S0; clear the counter.
  - Go to SHIFT. req_ready is never asserted outside IDLE.
- SHIFT, T1..TWIDTH: present shift_reg MSB to the detector, shift left, decrement the bit counter. After WIDTH bits, go to DRAIN.
- DRAIN, TWIDTH+1: one cycle to absorb the detector's registered hit for the last bit.
- Counting: counter increments on every cycle in SHIFT or DRAIN where det_hit=1; saturates at all-ones.
- RESP, from TWIDTH+2:
  - rsp_valid=1; rsp_id and rsp_count are stable while rsp_valid=1.
  - On rsp_valid&&rsp_ready, go to IDLE and update the pointer to g.
  - rsp_valid drops the following cycle. Back-to-back words need a minimum of WIDTH+3 cycles each.
- No cross-word matching: the detector is cleared on every accept.
- Detector (Moore, overlapping, clear input forces S0):
  - S0: 1→S1, 0→S0
  - S1: 1→S1, 0→S2
  - S2: 1→S3, 0→S0
  - S3: 1→S1, 0→S4
  - S4: 1→S3, 0→S0
  - det_hit = (state==S4): asserted one cycle after the final 0 is sampled.
- A req_valid deassertion while not granted is legal and not latched. A requester must hold data stable while valid=1 and ready=0.
- Reset mid-SHIFT/DRAIN/RESP: the word is dropped with no response, and the pointer is reset.

Decomposition:
- Shared package seq_scan_pkg holds:
  - controller state enum (IDLE, SHIFT, DRAIN, RESP)
  - detector state enum (S0..S4)
  - the pattern constant 4'b1010
- Sub-module seq1010_det (clk, reset, clr, bit_in, hit): the Moore detector above, instantiated once.

Test Plan:
- req0 sends 8'b10101010, rsp_ready=1 → rsp_valid at T10, rsp_id=0, rsp_count=3.
- req1 alone sends 8'b00001010 → rsp_count=1; the hit on the last bit is caught in DRAIN. Then req1 sends 8'b10100000 → rsp_count=1.
- Cross-word isolation: req0 sends 8'b00000010, then 8'b10000000 → both rsp_count=0.
- Both req_valid held high with words 8'hAA and 8'h0A → grant order 0,1,0,1. rsp_id sequence 0,1,0,1; counts 3,1,3,1. req_ready is never set for two indices at once.
- rsp_ready held low 5 cycles in RESP → rsp_valid/rsp_id/rsp_count stay stable, busy=1, no req_ready asserted. Release → IDLE on the next cycle.
- Assert reset at T4 of a SHIFT → next cycle: IDLE, busy=0, rsp_valid=0, no response for that word. Req0 wins the next arbitration even if req1 is also valid.
